// File: rtl/adrv9001_serdes_unpack.sv
// Transmit-side I/Q unpacker: 2-word sample FIFO feeding byte-wide I/Q/strobe
// lanes for the OSERDES, upper byte first, with 8-on/8-off or 1-on/15-off strobe.
module adrv9001_serdes_unpack #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [7:0]  IDLE_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        strb_mode,
  input  logic [15:0] i_in,
  input  logic [15:0] q_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  i_out,
  output logic [7:0]  q_out,
  output logic [7:0]  strb_out,
  output logic        underflow
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    PH_UPPER = 1'b0,
    PH_LOWER = 1'b1
  } phase_t;

  logic [15:0]   mem_i_q [FIFO_DEPTH];
  logic [15:0]   mem_q_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  phase_t        phase_q,  phase_d;
  logic          loaded_q, loaded_d;
  logic [7:0]    hold_i_q, hold_i_d;
  logic [7:0]    hold_q_q, hold_q_d;
  logic [7:0]    i_out_q,  i_out_d;
  logic [7:0]    q_out_q,  q_out_d;
  logic [7:0]    strb_q,   strb_d;
  logic          uf_q,     uf_d;
  logic          push, pop;

  assign ready_out = (count_q != CW'(FIFO_DEPTH));
  assign push      = valid_in && ready_out;
  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign strb_out  = strb_q;
  assign underflow = uf_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_i_q[wr_ptr_q] <= i_in;
      mem_q_q[wr_ptr_q] <= q_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      phase_q  <= PH_UPPER;
      loaded_q <= 1'b0;
      hold_i_q <= '0;
      hold_q_q <= '0;
      i_out_q  <= IDLE_VALUE;
      q_out_q  <= IDLE_VALUE;
      strb_q   <= '0;
      uf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      loaded_q <= loaded_d;
      hold_i_q <= hold_i_d;
      hold_q_q <= hold_q_d;
      i_out_q  <= i_out_d;
      q_out_q  <= q_out_d;
      strb_q   <= strb_d;
      uf_q     <= uf_d;
    end
  end

  always_comb begin
    pop      = 1'b0;
    phase_d  = phase_q;
    loaded_d = 1'b0;
    hold_i_d = hold_i_q;
    hold_q_d = hold_q_q;
    i_out_d  = IDLE_VALUE;
    q_out_d  = IDLE_VALUE;
    strb_d   = '0;
    uf_d     = 1'b0;

    if (!enable) begin
      phase_d = PH_UPPER;
    end else if (phase_q == PH_UPPER) begin
      phase_d = PH_LOWER;
      // Pop decision uses the pre-push count, so a word landing this edge waits.
      if (count_q != '0) begin
        pop      = 1'b1;
        loaded_d = 1'b1;
        i_out_d  = mem_i_q[rd_ptr_q][15:8];
        q_out_d  = mem_q_q[rd_ptr_q][15:8];
        hold_i_d = mem_i_q[rd_ptr_q][7:0];
        hold_q_d = mem_q_q[rd_ptr_q][7:0];
        strb_d   = strb_mode ? 8'h80 : 8'hFF;
      end else begin
        uf_d = 1'b1;
      end
    end else begin
      phase_d = PH_UPPER;
      // An unloaded lower slot stays idle to keep frame alignment.
      if (loaded_q) begin
        i_out_d = hold_i_q;
        q_out_d = hold_q_q;
      end
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

endmodule

// File: tb/tb_adrv9001_serdes_unpack.sv
// Directed self-checking bench for adrv9001_serdes_unpack.
module tb_adrv9001_serdes_unpack;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        strb_mode;
  logic [15:0] i_in;
  logic [15:0] q_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  i_out;
  logic [7:0]  q_out;
  logic [7:0]  strb_out;
  logic        underflow;

  int unsigned n_checks;
  int unsigned n_errors;

  adrv9001_serdes_unpack #(
    .FIFO_DEPTH (2),
    .IDLE_VALUE (8'h00)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .strb_mode (strb_mode),
    .i_in      (i_in),
    .q_in      (q_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .i_out     (i_out),
    .q_out     (q_out),
    .strb_out  (strb_out),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic lanes(input string tag, input logic [7:0] ei, input logic [7:0] eq,
                       input logic [7:0] es, input logic eu);
    check({tag, ".i"},    32'(i_out),     32'(ei));
    check({tag, ".q"},    32'(q_out),     32'(eq));
    check({tag, ".strb"}, 32'(strb_out),  32'(es));
    check({tag, ".uf"},   32'(underflow), 32'(eu));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned k;
    logic        acc;
    int unsigned f;

    n_checks = 0;
    n_errors = 0;

    // Reset with enable and valid asserted
    rstn = 1'b0; enable = 1'b1; strb_mode = 1'b0;
    valid_in = 1'b1; i_in = 16'hA55A; q_in = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    lanes("rst", 8'h00, 8'h00, 8'h00, 1'b0);
    check("rst.ready", 32'(ready_out), 32'd1);
    enable = 1'b0;
    #2 rstn = 1'b1;
    tick();
    lanes("rst_rel", 8'h00, 8'h00, 8'h00, 1'b0);
    check("rst_rel.ready", 32'(ready_out), 32'd1);
    valid_in = 1'b0;

    // Single word, mode 0
    enable = 1'b1;
    tick(); lanes("w0_hi",   8'hA5, 8'h12, 8'hFF, 1'b0);
    tick(); lanes("w0_lo",   8'h5A, 8'h34, 8'h00, 1'b0);
    tick(); lanes("w0_uf",   8'h00, 8'h00, 8'h00, 1'b1);
    tick(); lanes("w0_idle", 8'h00, 8'h00, 8'h00, 1'b0);
    enable = 1'b0;
    tick();

    // Mode 1 stream, FIFO pre-filled to full
    strb_mode = 1'b1;
    valid_in = 1'b1; i_in = 16'h0102; q_in = 16'hFEFD;
    tick();
    i_in = 16'h0304; q_in = 16'hFCFB;
    tick();
    check("m1_full.ready", 32'(ready_out), 32'd0);
    i_in = 16'h0506; q_in = 16'hFAF9;
    enable = 1'b1;
    tick(); lanes("m1_01", 8'h01, 8'hFE, 8'h80, 1'b0);
    check("m1_01.ready", 32'(ready_out), 32'd1);
    tick(); lanes("m1_02", 8'h02, 8'hFD, 8'h00, 1'b0);
    check("m1_02.ready", 32'(ready_out), 32'd0);
    valid_in = 1'b0;
    tick(); lanes("m1_03", 8'h03, 8'hFC, 8'h80, 1'b0);
    tick(); lanes("m1_04", 8'h04, 8'hFB, 8'h00, 1'b0);
    tick(); lanes("m1_05", 8'h05, 8'hFA, 8'h80, 1'b0);
    tick(); lanes("m1_06", 8'h06, 8'hF9, 8'h00, 1'b0);
    tick(); lanes("m1_uf", 8'h00, 8'h00, 8'h00, 1'b1);
    enable = 1'b0;
    tick();

    // Backpressure: source presents incrementing words every cycle
    strb_mode = 1'b0;
    k = 0;
    valid_in = 1'b1;
    i_in = {8'(8'h10 + k), 8'(8'h20 + k)};
    q_in = {8'(8'h30 + k), 8'(8'h40 + k)};
    for (int n = 0; n < 2; n++) begin
      acc = ready_out;
      tick();
      if (acc) k++;
      i_in = {8'(8'h10 + k), 8'(8'h20 + k)};
      q_in = {8'(8'h30 + k), 8'(8'h40 + k)};
    end
    check("bp_prefill.accepted", 32'(k), 32'd2);
    enable = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      if (j > 20) valid_in = 1'b0;
      acc = ready_out & valid_in;
      tick();
      if (acc) k++;
      i_in = {8'(8'h10 + k), 8'(8'h20 + k)};
      q_in = {8'(8'h30 + k), 8'(8'h40 + k)};
      f = (j - 1) / 2;
      if (j % 2 == 1)
        lanes($sformatf("bp_hi%0d", f), 8'(8'h10 + f), 8'(8'h30 + f), 8'hFF, 1'b0);
      else
        lanes($sformatf("bp_lo%0d", f), 8'(8'h20 + f), 8'(8'h40 + f), 8'h00, 1'b0);
      if (j <= 20)
        check($sformatf("bp_ready%0d", j), 32'(ready_out), (j % 2 == 1) ? 32'd1 : 32'd0);
      if (j == 20)
        check("bp.accepted", 32'(k), 32'd12);
    end
    tick(); lanes("bp_drain_uf", 8'h00, 8'h00, 8'h00, 1'b1);
    enable = 1'b0;
    tick();

    // Underflow on empty FIFO, then a word pushed in a phase-1 cycle
    enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      lanes($sformatf("uf_c%0d", c), 8'h00, 8'h00, 8'h00, (c % 2 == 0) ? 1'b1 : 1'b0);
    end
    valid_in = 1'b1; i_in = 16'hBEEF; q_in = 16'h0F0F;
    tick(); lanes("uf_c5", 8'h00, 8'h00, 8'h00, 1'b0);
    valid_in = 1'b0;
    tick(); lanes("beef_hi", 8'hBE, 8'h0F, 8'hFF, 1'b0);
    tick(); lanes("beef_lo", 8'hEF, 8'h0F, 8'h00, 1'b0);
    // Word arriving on the underflow edge must wait a full slot
    valid_in = 1'b1; i_in = 16'hD00D; q_in = 16'h1111;
    tick(); lanes("align_uf", 8'h00, 8'h00, 8'h00, 1'b1);
    valid_in = 1'b0;
    tick(); lanes("align_idle", 8'h00, 8'h00, 8'h00, 1'b0);
    tick(); lanes("align_hi", 8'hD0, 8'h11, 8'hFF, 1'b0);
    tick(); lanes("align_lo", 8'h0D, 8'h11, 8'h00, 1'b0);
    enable = 1'b0;
    tick();

    // Disable mid-frame, re-enable, async reset mid-frame
    valid_in = 1'b1; i_in = 16'hCAFE; q_in = 16'h1357;
    tick();
    i_in = 16'h7788; q_in = 16'h99AA;
    tick();
    valid_in = 1'b0;
    enable = 1'b1;
    tick(); lanes("cafe_hi", 8'hCA, 8'h13, 8'hFF, 1'b0);
    enable = 1'b0;
    tick(); lanes("dis_idle", 8'h00, 8'h00, 8'h00, 1'b0);
    check("dis.ready", 32'(ready_out), 32'd1);
    valid_in = 1'b1; i_in = 16'h4242; q_in = 16'h2424;
    tick();
    valid_in = 1'b0;
    check("dis_push.ready", 32'(ready_out), 32'd0);
    lanes("dis_push", 8'h00, 8'h00, 8'h00, 1'b0);
    enable = 1'b1;
    tick(); lanes("re_hi", 8'h77, 8'h99, 8'hFF, 1'b0);
    tick(); lanes("re_lo", 8'h88, 8'hAA, 8'h00, 1'b0);
    tick(); lanes("w42_hi", 8'h42, 8'h24, 8'hFF, 1'b0);
    #2 rstn = 1'b0;
    #1;
    lanes("arst", 8'h00, 8'h00, 8'h00, 1'b0);
    check("arst.ready", 32'(ready_out), 32'd1);
    enable = 1'b0;
    #3 rstn = 1'b1;
    tick(); lanes("arst_rel", 8'h00, 8'h00, 8'h00, 1'b0);
    check("arst_rel.ready", 32'(ready_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adrv9001_serdes_unpack.md
Name: adrv9001_serdes_unpack

Overview:
Transmit-side counterpart of the receive packer in the ADRV9001 serdes datapath. Accepts 16-bit I/Q sample words over a valid/ready handshake and buffers them in a 2-entry FIFO. Serialises each word onto 8-bit I, Q and strobe lanes that feed the OSERDES, one byte per clk, upper byte first. Generates the frame strobe in either 8-on/8-off or 1-on/15-off format and flags underflow when a frame slot has no data.

Parameters:
FIFO_DEPTH, 2, sample buffer depth in words; only 2 is supported (count 0..2).
IDLE_VALUE, 8'h00, byte driven on i_out/q_out when idle or underflowed.

Ports:
clk  input  1  main clock, serdes parallel rate
rstn  input  1  asynchronous active-low reset
enable  input  1  1 = run framer; 0 = hold outputs idle, phase forced to 0
strb_mode  input  1  0 = 8-on/8-off strobe; 1 = 1-on/15-off strobe
i_in  input  16  I sample word
q_in  input  16  Q sample word
valid_in  input  1  i_in/q_in valid
ready_out  output  1  FIFO can accept a word this cycle
i_out  output  8  I byte to serdes, MSB = first serial bit
q_out  output  8  Q byte to serdes
strb_out  output  8  strobe byte to serdes
underflow  output  1  one-cycle pulse: frame slot started with FIFO empty

Behaviour:
- Reset (rstn low, async): FIFO count=0, pointers=0, phase=0, i_out=q_out=IDLE_VALUE, strb_out=8'h00, underflow=0. ready_out reads 1 after reset release (combinational: count<2).
- Push: on rising clk with valid_in & ready_out, {i_in,q_in} written at the tail; count+1. Push is independent of enable.
- ready_out = (count != 2). No push when full; data is held by the source.
- All lane outputs registered. Phase toggles 0->1->0 every clk while enable=1.
- Edge with enable=1, phase=0, count>0: pop head; i_out<=head_i[15:8], q_out<=head_q[15:8]; hold_i/hold_q<=low bytes; strb_out<=8'hFF (mode 0) or 8'h80 (mode 1); underflow<=0; phase<=1.
- Edge with enable=1, phase=1, frame loaded: i_out<=hold_i, q_out<=hold_q, strb_out<=8'h00; phase<=0.
- Edge with enable=1, phase=0, count=0: i_out=q_out=IDLE_VALUE, strb_out=8'h00, underflow<=1 for exactly this cycle; phase<=1. The following phase-1 cycle is also idle, even if a word arrives meanwhile, so frame alignment is kept. underflow<=0 on every other edge.
- Simultaneous push and pop on the same edge: count unchanged; a word pushed into an empty FIFO cannot be popped on the same edge.
- Min latency: word accepted at edge E with FIFO empty; upper byte is on the outputs after edge E+1 if phase=0 at E+1, else after E+2.
- Sustained throughput: 1 word per 2 clk. A source presenting a word every cycle sees ready_out toggle once the FIFO is full.
- enable falling mid-frame: the next edge forces phase=0, idle outputs, strb_out=0, underflow=0. The pending low byte is discarded, and popped words are not replayed. FIFO contents are retained.
- strb_mode is sampled only at phase-0 pop edges; a change mid-frame takes effect at the next frame.
- Round trip: the upper/lower byte order matches the receive packer, so loopback through the packer reproduces i_in/q_in/strobe framing.

Test Plan:
- Reset: hold rstn=0 with enable=1 and valid_in=1 -> i_out=q_out=00, strb_out=00, underflow=0, ready_out=1. Release -> first push accepted.
- Single word, mode 0: push i=16'hA55A, q=16'h1234, then enable -> output sequence (A5,12,FF) then (5A,34,00), then idle with underflow pulse at the next phase-0 slot.
- Mode 1 stream: push 16'h0102, 16'h0304, 16'h0506 back-to-back with enable=1 -> i_out bytes 01,02,03,04,05,06; strb_out 80,00,80,00,80,00; underflow=0 throughout; ready_out deasserts when count=2.
- Backpressure: valid_in held high with incrementing data for 20 cycles -> no word lost or duplicated; accepted words equal output frames; ready_out alternates once full.
- Underflow: enable=1 with empty FIFO for 6 cycles -> underflow high on cycles 0,2,4 only; strb_out=00. Push 16'hBEEF during a phase-1 cycle -> BE appears at the next phase-0 slot, never misaligned.
- Disable mid-frame: after the upper byte of 16'hCAFE, drop enable -> next cycle outputs 00/strobe 00, FE never emitted. Re-enable -> next queued word starts at phase 0. Async rstn pulse mid-frame -> outputs idle immediately.
